// File: rtl/audio_pkg.sv
// Shared definitions for the WM8731 audio datapath: default word width,
// receive FSM states and the L/R channel encoding carried on lrck.
package audio_pkg;

  localparam int AUDIO_DATA_W = 16;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } rx_state_e;

  // lrck low selects the left channel, high selects the right channel.
  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

endpackage : audio_pkg

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous 1-bit input, with a one-cycle
// strobe on each synchronised rising edge. STAGES must be at least 2.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule : sync_edge

// File: rtl/i2s_adc_rx.sv
// WM8731 ADC receive path: oversamples bclk/lrck/adcdat on sys_clk, deframes
// I2S left/right words and presents each pair on a valid/ready interface.
module i2s_adc_rx
  import audio_pkg::*;
#(
  parameter int DATA_W      = AUDIO_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              bclk,
  input  logic              lrck,
  input  logic              adcdat,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  output logic              frame_err,
  input  logic              err_clr
);

  localparam int             CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic bclk_s, bclk_rise;
  logic lrck_s, lrck_rise;
  logic adcdat_s, adcdat_rise;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk (sys_clk), .rst (sys_rst), .d (bclk),   .q (bclk_s),   .rise (bclk_rise)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrck (
    .clk (sys_clk), .rst (sys_rst), .d (lrck),   .q (lrck_s),   .rise (lrck_rise)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_adcdat (
    .clk (sys_clk), .rst (sys_rst), .d (adcdat), .q (adcdat_s), .rise (adcdat_rise)
  );

  // Only the bclk strobe drives the protocol; the other outputs are spare.
  logic unused_sync;
  assign unused_sync = bclk_s ^ lrck_rise ^ adcdat_rise;

  rx_state_e         state_q, state_d;
  channel_e          chan_q, chan_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] left_hold_q, left_hold_d;
  logic              lrck_prev_q, lrck_prev_d;
  logic [DATA_W-1:0] left_data_q, left_data_d;
  logic [DATA_W-1:0] right_data_q, right_data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;

  logic [DATA_W-1:0] shreg_shift;
  logic              lrck_edge;
  logic              pair_done;
  logic              frame_err_set;
  logic              overrun_set;

  assign shreg_shift = {shreg_q[DATA_W-2:0], adcdat_s};
  assign lrck_edge   = (lrck_s != lrck_prev_q);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    chan_d        = chan_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    left_hold_d   = left_hold_q;
    lrck_prev_d   = lrck_prev_q;
    pair_done     = 1'b0;
    frame_err_set = 1'b0;

    if (bclk_rise) begin
      lrck_prev_d = lrck_s;
      unique case (state_q)
        ALIGN: begin
          if (lrck_edge && (lrck_s == CH_LEFT)) begin
            state_d   = SHIFT;
            chan_d    = CH_LEFT;
            bit_cnt_d = CNT_LOAD;
          end
        end
        SHIFT: begin
          if (lrck_edge) begin
            // Short word: drop it and start collecting the new channel.
            frame_err_set = 1'b1;
            chan_d        = channel_e'(lrck_s);
            bit_cnt_d     = CNT_LOAD;
            shreg_d       = '0;
          end else begin
            shreg_d   = shreg_shift;
            bit_cnt_d = bit_cnt_q - CNT_ONE;
            if (bit_cnt_q == CNT_ONE) begin
              state_d = WAIT;
              if (chan_q == CH_LEFT) left_hold_d = shreg_shift;
              else                   pair_done   = 1'b1;
            end
          end
        end
        WAIT: begin
          if (lrck_edge) begin
            state_d   = SHIFT;
            chan_d    = channel_e'(lrck_s);
            bit_cnt_d = CNT_LOAD;
          end
        end
        default: state_d = ALIGN;
      endcase
    end
  end

  // Output pair register, valid/ready handshake and sticky error flags.
  always_comb begin
    left_data_d  = left_data_q;
    right_data_d = right_data_q;
    valid_d      = valid_q;
    overrun_set  = 1'b0;

    if (valid_q && sample_ready) valid_d = 1'b0;
    if (pair_done) begin
      valid_d      = 1'b1;
      left_data_d  = left_hold_q;
      right_data_d = shreg_shift;
      overrun_set  = valid_q && !sample_ready;
    end

    overrun_d   = (overrun_q   && !err_clr) || overrun_set;
    frame_err_d = (frame_err_q && !err_clr) || frame_err_set;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ALIGN;
      chan_q       <= CH_LEFT;
      bit_cnt_q    <= CNT_LOAD;
      shreg_q      <= '0;
      left_hold_q  <= '0;
      lrck_prev_q  <= 1'b0;
      left_data_q  <= '0;
      right_data_q <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      left_hold_q  <= left_hold_d;
      lrck_prev_q  <= lrck_prev_d;
      left_data_q  <= left_data_d;
      right_data_q <= right_data_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign left_data    = left_data_q;
  assign right_data   = right_data_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign frame_err    = frame_err_q;

endmodule : i2s_adc_rx

// File: tb/tb_i2s_adc_rx.sv
// Directed bench for i2s_adc_rx: drives I2S frames on the pins and compares
// delivered pairs and flags against hand-computed values.
module tb_i2s_adc_rx;

  localparam int DATA_W = 16;
  localparam int SYNC   = 2;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              bclk    = 1'b0;
  logic              lrck    = 1'b1;
  logic              adcdat  = 1'b0;
  logic              sample_ready = 1'b0;
  logic              err_clr = 1'b0;
  logic [DATA_W-1:0] left_data, right_data;
  logic              sample_valid, overrun, frame_err;

  int n_checks = 0;
  int n_errs   = 0;
  logic [31:0] pairs[$];

  i2s_adc_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .bclk         (bclk),
    .lrck         (lrck),
    .adcdat       (adcdat),
    .left_data    (left_data),
    .right_data   (right_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .frame_err    (frame_err),
    .err_clr      (err_clr)
  );

  always #10 sys_clk = ~sys_clk;

  // Record every accepted pair as {left, right}.
  always @(negedge sys_clk) begin
    if (!sys_rst && sample_valid && sample_ready) pairs.push_back({left_data, right_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One lrck half-period of nclk bclk periods; word MSB goes out on the
  // period after the lrck change. Optionally pulse sample_ready in the cycle
  // where the DUT strobes the LSB.
  task automatic send_half(input logic lr, input logic [DATA_W-1:0] word,
                           input int nclk, input bit rdy_pulse);
    for (int i = 0; i < nclk; i++) begin
      @(negedge sys_clk);
      bclk   = 1'b0;
      lrck   = lr;
      adcdat = (i >= 1 && i <= DATA_W) ? word[DATA_W-i] : 1'b0;
      repeat (3) @(negedge sys_clk);
      bclk = 1'b1;
      if (rdy_pulse && i == DATA_W) begin
        repeat (SYNC) @(negedge sys_clk);
        sample_ready = 1'b1;
        @(negedge sys_clk);
        sample_ready = 1'b0;
      end else begin
        repeat (3) @(negedge sys_clk);
      end
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                            input bit rdy_pulse);
    send_half(1'b0, l, 32, 1'b0);
    send_half(1'b1, r, 32, rdy_pulse);
  endtask

  task automatic pulse_rst();
    @(negedge sys_clk); sys_rst = 1'b1;
    @(negedge sys_clk); sys_rst = 1'b0;
  endtask

  task automatic pulse_err_clr();
    @(negedge sys_clk); err_clr = 1'b1;
    @(negedge sys_clk); err_clr = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_left"},  32'(left_data),    32'h0);
    check({tag, "_right"}, 32'(right_data),   32'h0);
    check({tag, "_valid"}, 32'(sample_valid), 32'h0);
    check({tag, "_ovr"},   32'(overrun),      32'h0);
    check({tag, "_ferr"},  32'(frame_err),    32'h0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (4) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_zero("reset");

    // Basic frame after alignment preamble.
    sample_ready = 1'b1;
    send_half(1'b1, 16'h0000, 32, 1'b0);
    send_frame(16'h1234, 16'hABCD, 1'b0);
    check("basic_count", 32'(pairs.size()), 32'd1);
    if (pairs.size() > 0) check("basic_pair", pairs[0], 32'h1234_ABCD);
    check("basic_valid", 32'(sample_valid), 32'h0);
    check("basic_ovr",   32'(overrun),      32'h0);
    check("basic_ferr",  32'(frame_err),    32'h0);

    // Start mid right channel: partial word must never be reported.
    pulse_rst();
    pairs.delete();
    send_half(1'b1, 16'h5555, 32, 1'b0);
    send_frame(16'h8001, 16'h7FFE, 1'b0);
    check("mid_count", 32'(pairs.size()), 32'd1);
    if (pairs.size() > 0) check("mid_pair", pairs[0], 32'h8001_7FFE);

    // Overrun: two frames with no acceptance.
    sample_ready = 1'b0;
    pairs.delete();
    send_frame(16'h0001, 16'h0002, 1'b0);
    check("ovr_first_ovr", 32'(overrun), 32'h0);
    send_frame(16'h0003, 16'h0004, 1'b0);
    check("ovr_flag",  32'(overrun),      32'h1);
    check("ovr_valid", 32'(sample_valid), 32'h1);
    check("ovr_left",  32'(left_data),    32'h0003);
    check("ovr_right", 32'(right_data),   32'h0004);
    check("ovr_count", 32'(pairs.size()), 32'd0);
    pulse_err_clr();
    check("ovr_clr", 32'(overrun), 32'h0);
    @(negedge sys_clk); sample_ready = 1'b1;
    @(negedge sys_clk);
    check("ovr_drain", 32'(sample_valid), 32'h0);
    if (pairs.size() > 0) check("ovr_drain_pair", pairs[$], 32'h0003_0004);

    // Short left word (10 bits) then a clean frame.
    pairs.delete();
    send_half(1'b0, 16'hFFFF, 11, 1'b0);
    send_half(1'b1, 16'h1111, 32, 1'b0);
    check("ferr_flag", 32'(frame_err), 32'h1);
    send_frame(16'h0F0F, 16'hF0F0, 1'b0);
    check("ferr_sticky", 32'(frame_err), 32'h1);
    check("ferr_nonempty", 32'(pairs.size() > 0), 32'h1);
    if (pairs.size() > 0) check("ferr_pair", pairs[$], 32'h0F0F_F0F0);
    check("ferr_ovr", 32'(overrun), 32'h0);
    pulse_err_clr();
    check("ferr_clr", 32'(frame_err), 32'h0);

    // Acceptance in the exact completion cycle of the next pair.
    sample_ready = 1'b0;
    pairs.delete();
    send_frame(16'h1111, 16'h2222, 1'b0);
    check("same_held", 32'(sample_valid), 32'h1);
    send_frame(16'h4444, 16'h8888, 1'b1);
    check("same_valid", 32'(sample_valid), 32'h1);
    check("same_left",  32'(left_data),    32'h4444);
    check("same_right", 32'(right_data),   32'h8888);
    check("same_ovr",   32'(overrun),      32'h0);
    check("same_count", 32'(pairs.size()), 32'd1);
    if (pairs.size() > 0) check("same_pair", pairs[0], 32'h1111_2222);
    @(negedge sys_clk); sample_ready = 1'b1;
    @(negedge sys_clk);

    // Reset during bit 8 of a right word, then re-alignment.
    pairs.delete();
    send_half(1'b0, 16'h6666, 32, 1'b0);
    send_half(1'b1, 16'h7777, 9, 1'b0);
    pulse_rst();
    check_zero("midrst");
    send_half(1'b1, 16'h0000, 32, 1'b0);
    send_frame(16'h2222, 16'h3333, 1'b0);
    check("rst_count", 32'(pairs.size()), 32'd1);
    if (pairs.size() > 0) check("rst_pair", pairs[0], 32'h2222_3333);
    check("rst_ferr", 32'(frame_err), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule : tb_i2s_adc_rx

// File: doc/i2s_adc_rx.md
# i2s_adc_rx

Receive path for the WM8731 audio codec: deserialises the codec's I2S ADC stream into parallel left/right PCM samples on `sys_clk` (50 MHz). The FPGA is bit-clock master. `AUD_BCLK` and `AUD_ADCLRCK` are driven by the existing DAC-side logic and observed here as asynchronous inputs, and `AUD_ADCDAT` is captured. Sample pairs are presented on a valid/ready interface to downstream processing (loopback to the DAC, metering).

## Interface
Parameters:
- `DATA_W`, 16: bits per channel word captured (MSB first).
- `SYNC_STAGES`, 2: synchroniser flops on `bclk`, `lrck`, `adcdat`.

Ports:
- `sys_clk` in 1: system clock, 50 MHz.
- `sys_rst` in 1: synchronous, active-high reset.
- `bclk` in 1: I2S bit clock (asynchronous to `sys_clk`; ≤ 3.1 MHz).
- `lrck` in 1: ADC L/R clock. Low = left, high = right.
- `adcdat` in 1: serial ADC data. Changes on `bclk` falling edge.
- `left_data` out DATA_W: left sample, two's complement.
- `right_data` out DATA_W: right sample.
- `sample_valid` out 1: pair available. Held until accepted.
- `sample_ready` in 1: consumer accepts the pair when high with `sample_valid`.
- `overrun` out 1: sticky; a pair was overwritten before acceptance.
- `frame_err` out 1: sticky; `lrck` toggled before DATA_W bits were captured.
- `err_clr` in 1: one-cycle pulse; clears `overrun` and `frame_err`.

## Operation
- Each input passes through a SYNC_STAGES synchroniser. A `bclk` rising edge is detected as sync output = 1 with the previous value = 0. All protocol actions occur only on that one-cycle strobe `bclk_rise`.
- On each `bclk_rise`, sample the synchronised `lrck` and `adcdat` and compare with `lrck_prev`.
- FSM:
  - ALIGN (reset state): wait for the first `lrck` 1→0 transition, i.e. the start of left, then go to SHIFT. Any partial frame after reset is ignored.
  - SHIFT: on each `bclk_rise` after the transition rise, shift `adcdat` into `shreg` (MSB first). I2S gives a one-bit delay, so the MSB arrives on the rise after the one where the `lrck` change is seen. Decrement `bit_cnt` (loaded with DATA_W). At 0, latch the word into the channel holding register and go to WAIT.
  - WAIT: ignore bits until the next `lrck` transition. Then reload `bit_cnt`, set the channel from the new `lrck` value, and go to SHIFT.
  - `lrck` transition while in SHIFT with `bit_cnt` ≠ 0: discard the partial word, set `frame_err`, and restart SHIFT for the new channel.
- Pair completion occurs when the right word latches. At that point, `left_data`/`right_data` load from the holding registers and `sample_valid` is set.
  - If `sample_valid` was already 1 and `sample_ready` is 0 in that cycle, set `overrun` and overwrite the pair.
  - If `sample_ready` is 1 in the same cycle, this is a normal acceptance plus a new load: `sample_valid` stays 1 and there is no overrun.
- Handshake: `sample_valid && sample_ready` clears `sample_valid` next cycle unless a completion coincides. `left_data`/`right_data` are stable while `sample_valid` is 1.
- `err_clr` coinciding with a new error event: the set wins.

## Timing
- Reset values: `left_data`=0, `right_data`=0, `sample_valid`=0, `overrun`=0, `frame_err`=0, FSM=ALIGN, `bit_cnt`=DATA_W, `shreg`=0.
- Input-to-strobe latency is SYNC_STAGES+1 `sys_clk` cycles after a `bclk` pin edge.
- `sample_valid` rises one `sys_clk` after the `bclk_rise` that captures the right-channel LSB.
- Requires ≥ DATA_W+1 `bclk` periods per `lrck` half-period, and a `bclk` high/low time ≥ 3 `sys_clk` periods.
- `sys_rst` mid-word: everything returns to reset values in one cycle and the block re-aligns on the next left-channel start.

## Structure
- Shared package `audio_pkg`: `AUDIO_DATA_W` (16) default, FSM state enum (`ALIGN`, `SHIFT`, `WAIT`), L/R channel encoding constant.
- Sub-module `sync_edge`: SYNC_STAGES-flop synchroniser with rising-edge strobe output. Instantiated for `bclk`, and as synchroniser only for `lrck` and `adcdat`.
- Top `i2s_adc_rx`: FSM, bit counter, shift register, holding registers, handshake and sticky flags.

## Test plan
- Reset, then 64-bclk frames with left=0x1234, right=0xABCD, `sample_ready`=1 → one `sample_valid` pulse with `left_data`=0x1234, `right_data`=0xABCD; flags stay 0.
- Stimulus starts mid right channel with right=0x5555, then a full frame L=0x8001/R=0x7FFE → the first pair reported is 0x8001/0x7FFE; the partial 0x5555 is never output.
- `sample_ready`=0 across two frames (L/R 0x0001/0x0002, then 0x0003/0x0004) → `overrun`=1; outputs are 0x0003/0x0004; `err_clr` returns `overrun` to 0.
- `lrck` toggles after 10 bits of a left word → `frame_err`=1; the following complete frame 0x0F0F/0xF0F0 is still delivered correctly.
- `sample_ready` asserted in the exact completion cycle of the next pair → `sample_valid` stays 1, new data loads, `overrun`=0.
- `sys_rst` pulse during bit 8 of a right word → all outputs 0 next cycle; the next full frame 0x2222/0x3333 is delivered after re-alignment.
